// File: rtl/video_pkg.sv
// video_pkg: shared frame geometry, fetch phases and video-RAM address helper
package video_pkg;
  localparam int H_TOT = 448;
  localparam int V_TOT = 320;
  localparam int INT_CLKS = 32;
  localparam int FETCH_LEAD = 8;
  localparam logic [8:0] H_PAPER = 9'd256;
  localparam logic [8:0] V_PAPER = 9'd192;
  localparam logic [8:0] H_BLANK = 9'd320;
  localparam logic [8:0] V_BLANK_S = 9'd240;
  localparam logic [8:0] V_BLANK_E = 9'd255;
  localparam logic [8:0] H_SYNC_S = 9'd328;
  localparam logic [8:0] H_SYNC_E = 9'd359;
  localparam logic [8:0] V_SYNC_S = 9'd240;
  localparam logic [8:0] V_SYNC_E = 9'd243;
  localparam logic [8:0] INT_V = 9'd239;
  localparam logic [8:0] INT_H = 9'd320;
  localparam logic [13:0] ATTR_BASE = 14'h1800;
  typedef enum logic [2:0] {
    PH_PIX_ADDR, PH_PIX_LD, PH_ATTR_ADDR, PH_ATTR_LD,
    PH_CPU0, PH_CPU1, PH_CPU2, PH_SHIFT
  } phase_e;
  // Pixel bytes use the interleaved line order; attributes are one byte per 8x8 cell
  function automatic logic [13:0] fetch_addr(input logic attr, input logic [7:0] vt, input logic [4:0] col);
    return attr ? ATTR_BASE + {4'd0, vt[7:3], col} : {1'b0, vt[7:6], vt[2:0], vt[5:3], col};
  endfunction
endpackage

// File: rtl/video_arb.sv
// video_arb: grants CPU video-RAM access in cycles the video fetch leaves free
module video_arb (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  input  logic vid_i,
  output logic ack_o,
  output logic wait_o
);
  logic ack_q, ack_d, armed_q, armed_d;
  // vid_i is next cycle's bus owner, so an ACK never lands on a video slot; a held request stays disarmed
  always_comb begin
    ack_d = req_i && !vid_i && armed_q;
    armed_d = !req_i || (armed_q && !ack_d);
  end
  // Grant pulse and re-arm state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      ack_q <= ack_d;
      armed_q <= armed_d;
    end
  end
  assign ack_o = ack_q;
  assign wait_o = req_i && !ack_q && armed_q;
endmodule

// File: rtl/video_timing.sv
// video_timing: raster counters, video-RAM fetch sequencing and display strobes
module video_timing
  import video_pkg::*;
#(
  parameter int H_TOTAL = H_TOT,
  parameter int V_TOTAL = V_TOT,
  parameter int INT_LEN = INT_CLKS
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  Q,
  input  logic        CPU_REQ,
  output logic [13:0] VA,
  output logic        MEM_VID,
  output logic        CPU_ACK,
  output logic        CPU_WAIT,
  output logic        LD_PIX,
  output logic        LD_ATTR,
  output logic        LD_SHIFT,
  output logic        BORDER,
  output logic        BL,
  output logic        SYNC,
  output logic        INT_N,
  output logic        FLASHER
);
  logic [8:0] h_q, h_d, v_q, v_d, vn, hf, vt;
  logic [7:0] frame_q, frame_d;
  logic [13:0] va_q, va_d;
  logic h_wrap, late, fetch, paper;
  logic mem_vid_q, mem_vid_d, ld_pix_q, ld_pix_d, ld_attr_q, ld_attr_d, ld_shift_q, ld_shift_d;
  logic border_q, border_d, bl_q, bl_d, sync_q, sync_d, int_n_q, int_n_d, flasher_q;
  phase_e ph;
  logic q_unused;
  assign q_unused = ^Q;
  // Decode from the next counter state so every registered output lines up with the H/V it describes
  always_comb begin
    h_wrap = h_q == 9'(H_TOTAL - 1);
    h_d = h_wrap ? '0 : h_q + 9'd1;
    v_d = !h_wrap ? v_q : v_q == 9'(V_TOTAL - 1) ? '0 : v_q + 9'd1;
    frame_d = frame_q + {7'd0, h_wrap && v_q == 9'(V_TOTAL - 1)};
    vn = v_d == 9'(V_TOTAL - 1) ? '0 : v_d + 9'd1;
    late = h_d >= 9'(H_TOTAL - FETCH_LEAD);
    hf = late ? h_d - 9'(H_TOTAL - FETCH_LEAD) : h_d + 9'(FETCH_LEAD);
    vt = late ? vn : v_d;
    ph = phase_e'(h_d[2:0]);
    fetch = hf < H_PAPER && vt < V_PAPER;
    mem_vid_d = fetch && ph < PH_CPU0;
    va_d = mem_vid_d ? fetch_addr(ph >= PH_ATTR_ADDR, vt[7:0], hf[7:3]) : va_q;
    ld_pix_d = fetch && ph == PH_PIX_LD;
    ld_attr_d = fetch && ph == PH_ATTR_LD;
    ld_shift_d = fetch && ph == PH_SHIFT;
    paper = h_d < H_PAPER && v_d < V_PAPER;
    bl_d = h_d >= H_BLANK || (v_d >= V_BLANK_S && v_d <= V_BLANK_E);
    border_d = !paper && !bl_d;
    sync_d = (h_d >= H_SYNC_S && h_d <= H_SYNC_E) || (v_d >= V_SYNC_S && v_d <= V_SYNC_E);
    int_n_d = !(v_d == INT_V && h_d >= INT_H && h_d < INT_H + 9'(INT_LEN));
  end
  // Counters and registered outputs; reset aborts any fetch or strobe in flight
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      h_q <= '0;
      v_q <= '0;
      frame_q <= '0;
      va_q <= '0;
      mem_vid_q <= 1'b0;
      ld_pix_q <= 1'b0;
      ld_attr_q <= 1'b0;
      ld_shift_q <= 1'b0;
      border_q <= 1'b0;
      bl_q <= 1'b0;
      sync_q <= 1'b0;
      int_n_q <= 1'b1;
      flasher_q <= 1'b0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
      frame_q <= frame_d;
      va_q <= va_d;
      mem_vid_q <= mem_vid_d;
      ld_pix_q <= ld_pix_d;
      ld_attr_q <= ld_attr_d;
      ld_shift_q <= ld_shift_d;
      border_q <= border_d;
      bl_q <= bl_d;
      sync_q <= sync_d;
      int_n_q <= int_n_d;
      flasher_q <= frame_d[4];
    end
  end
  video_arb u_arb (
    .clk_i(CLK),
    .rst_i(RST),
    .req_i(CPU_REQ),
    .vid_i(mem_vid_d),
    .ack_o(CPU_ACK),
    .wait_o(CPU_WAIT)
  );
  assign VA = va_q;
  assign MEM_VID = mem_vid_q;
  assign LD_PIX = ld_pix_q;
  assign LD_ATTR = ld_attr_q;
  assign LD_SHIFT = ld_shift_q;
  assign BORDER = border_q;
  assign BL = bl_q;
  assign SYNC = sync_q;
  assign INT_N = int_n_q;
  assign FLASHER = flasher_q;
endmodule
